// File: rtl/mc_dp_pkg.sv
// Shared encodings for the multicycle datapath: mux selects, ALU ops, extend modes,
// multiplier state constants and instruction field positions.
// No logic; imported by mc_datapath and mul_iter.
package mc_dp_pkg;

  // ALUSrcB select
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;
  localparam logic [1:0] SRCB_NONE = 2'b11;

  // ResultSrc select
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_NONE   = 2'b11;

  // ALUControl
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  // ImmSrc
  localparam logic [1:0] IMM_8   = 2'b00;
  localparam logic [1:0] IMM_12  = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;
  localparam logic [1:0] IMM_NONE = 2'b11;

  // Multiplier FSM states
  typedef logic [1:0] mul_state_t;
  localparam mul_state_t IDLE = 2'd0;
  localparam mul_state_t RUN  = 2'd1;
  localparam mul_state_t DONE = 2'd2;

  // Register field LSB positions inside IR
  localparam int RM_LSB = 0;
  localparam int RD_LSB = 12;
  localparam int RN_LSB = 16;

endpackage

// File: rtl/mc_datapath_if.sv
// Controller/memory bundle for mc_datapath: control inputs, flag/busy outputs, memory port.
// slave = datapath view, master = controller/memory view.
// No flow control: controller sequences everything; MulBusy tells it a multiply is in flight.
interface mc_datapath_if #(
  parameter int WIDTH = 32
);
  logic             PCWrite;
  logic             AdrSrc;
  logic             IRWrite;
  logic [1:0]       RegSrc;
  logic             RegWrite;
  logic [1:0]       ImmSrc;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUControl;
  logic [1:0]       ResultSrc;
  logic             MulStart;
  logic             MulLong;
  logic [WIDTH-1:0] Adr;
  logic [WIDTH-1:0] WriteData;
  logic [WIDTH-1:0] ReadData;
  logic [31:0]      Instr;
  logic [3:0]       ALUFlags;
  logic             MulBusy;
  logic             MulDone;

  modport master (
    output PCWrite, AdrSrc, IRWrite, RegSrc, RegWrite, ImmSrc, ALUSrcA, ALUSrcB,
           ALUControl, ResultSrc, MulStart, MulLong, ReadData,
    input  Adr, WriteData, Instr, ALUFlags, MulBusy, MulDone
  );

  modport slave (
    input  PCWrite, AdrSrc, IRWrite, RegSrc, RegWrite, ImmSrc, ALUSrcA, ALUSrcB,
           ALUControl, ResultSrc, MulStart, MulLong, ReadData,
    output Adr, WriteData, Instr, ALUFlags, MulBusy, MulDone
  );
endinterface

// File: rtl/mc_datapath_mul_iter.sv
// Iterative radix-2 shift-add unsigned multiplier; ports: clk, reset, start, long, a, b -> busy, done, lo, hi.
// Latency: WIDTH RUN cycles plus one DONE cycle after start is sampled.
// start is ignored while busy; product is 2*WIDTH bits with LONG_MUL_EN, else WIDTH bits (hi = 0).
module mul_iter
  import mc_dp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             long,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

`ifdef LONG_MUL_EN
  localparam int PW = 2 * WIDTH;
`else
  localparam int PW = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 1);

  mul_state_t       state;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    mcand;
  logic [PW-1:0]    prod;
  logic [WIDTH-1:0] mplier;

  // MUL/UMULL selection is resolved at writeback; the product is always full width.
  logic unused_long;
  assign unused_long = long;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      mcand  <= '0;
      prod   <= '0;
      mplier <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= RUN;
            mcand  <= PW'(a);
            mplier <= b;
            prod   <= '0;
            cnt    <= CW'(WIDTH);
          end
        end
        RUN: begin
          if (mplier[0]) prod <= prod + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign lo   = prod[WIDTH-1:0];
`ifdef LONG_MUL_EN
  assign hi   = prod[PW-1:WIDTH];
`else
  assign hi   = '0;
`endif

endmodule

// File: rtl/mc_datapath.sv
// Multicycle ARM-subset datapath: PC/IR/A/B/ALUOut/Data registers, regfile, ALU, extend, iterative multiplier.
// Ports: clk, reset (async, active-high), bus (mc_datapath_if.slave). Optional UMULL via LONG_MUL_EN.
// Latency: one edge per register stage; multiply takes WIDTH+1 cycles. No backpressure: MulBusy is advisory.
module mc_datapath
  import mc_dp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREG  = 16
) (
  input logic          clk,
  input logic          reset,
  mc_datapath_if.slave bus
);

  localparam int            AW     = $clog2(NREG);
  localparam logic [AW-1:0] PC_IDX = AW'(NREG - 1);

  logic [WIDTH-1:0] pc, a_q, b_q, alu_out_q, data_q;
  logic [31:0]      ir;
  logic [WIDTH-1:0] rf [NREG];

  logic [AW-1:0]    rn, rd, rm, ra1, ra2;
  logic [WIDTH-1:0] pc_plus4, rd1, rd2, ext_imm, src_a, src_b, alu_result, result;
  logic [WIDTH:0]   sum;
  logic             is_sub;

  logic             mul_busy, mul_done;
  logic [WIDTH-1:0] mul_lo, mul_hi, mul_wd1;

  assign rn = ir[RN_LSB +: AW];
  assign rd = ir[RD_LSB +: AW];
  assign rm = ir[RM_LSB +: AW];

  logic unused_ir;
  assign unused_ir = ^ir[31:24];

  // Register reads: the PC alias returns PC+4 instead of storage.
  assign ra1      = bus.RegSrc[0] ? PC_IDX : rn;
  assign ra2      = bus.RegSrc[1] ? rd : rm;
  assign pc_plus4 = pc + WIDTH'(4);
  assign rd1      = (ra1 == PC_IDX) ? pc_plus4 : rf[ra1];
  assign rd2      = (ra2 == PC_IDX) ? pc_plus4 : rf[ra2];

  always_comb begin
    ext_imm = '0;
    case (bus.ImmSrc)
      IMM_8:    ext_imm = WIDTH'(ir[7:0]);
      IMM_12:   ext_imm = WIDTH'(ir[11:0]);
      IMM_BR:   ext_imm = {{(WIDTH-26){ir[23]}}, ir[23:0], 2'b00};
      IMM_NONE: ext_imm = '0;
    endcase
  end

  assign src_a = bus.ALUSrcA ? pc : a_q;

  always_comb begin
    src_b = '0;
    case (bus.ALUSrcB)
      SRCB_REG:  src_b = b_q;
      SRCB_IMM:  src_b = ext_imm;
      SRCB_FOUR: src_b = WIDTH'(4);
      SRCB_NONE: src_b = '0;
    endcase
  end

  // Subtract as a + ~b + 1 so the carry out is the ARM "no borrow" carry.
  assign is_sub = (bus.ALUControl == ALU_SUB);
  assign sum    = {1'b0, src_a} + {1'b0, (is_sub ? ~src_b : src_b)} + (WIDTH+1)'(is_sub);

  always_comb begin
    alu_result = '0;
    case (bus.ALUControl)
      ALU_ADD: alu_result = sum[WIDTH-1:0];
      ALU_SUB: alu_result = sum[WIDTH-1:0];
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
    endcase
  end

  logic arith, flag_c, flag_v;
  assign arith  = ~bus.ALUControl[1];
  assign flag_c = arith & sum[WIDTH];
  assign flag_v = arith & (src_a[WIDTH-1] == (src_b[WIDTH-1] ^ is_sub))
                        & (sum[WIDTH-1] != src_a[WIDTH-1]);
  assign bus.ALUFlags = {alu_result[WIDTH-1], (alu_result == '0), flag_c, flag_v};

  always_comb begin
    result = '0;
    case (bus.ResultSrc)
      RES_ALUOUT: result = alu_out_q;
      RES_DATA:   result = data_q;
      RES_ALU:    result = alu_result;
      RES_NONE:   result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc        <= '0;
      ir        <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      data_q    <= '0;
    end else begin
      if (bus.PCWrite) pc <= result;
      if (bus.IRWrite) ir <= bus.ReadData[31:0];
      a_q       <= rd1;
      b_q       <= rd2;
      alu_out_q <= alu_result;
      data_q    <= bus.ReadData;
    end
  end

  mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .reset (reset),
    .start (bus.MulStart),
    .long  (bus.MulLong),
    .a     (a_q),
    .b     (b_q),
    .busy  (mul_busy),
    .done  (mul_done),
    .lo    (mul_lo),
    .hi    (mul_hi)
  );

`ifdef LONG_MUL_EN
  // Operation kind captured on the same edge the multiplier accepts its operands.
  logic mul_long_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          mul_long_q <= 1'b0;
    else if (bus.MulStart && !mul_busy) mul_long_q <= bus.MulLong;
  end
  assign mul_wd1 = mul_long_q ? mul_hi : mul_lo;
`else
  logic unused_hi;
  assign unused_hi = ^mul_hi;
  assign mul_wd1   = mul_lo;
`endif

  // Later assignments win: RegWrite < UMULL low half < Instr[19:16] multiplier write.
  always_ff @(posedge clk) begin
    if (bus.RegWrite && (rd != PC_IDX)) rf[rd] <= result;
`ifdef LONG_MUL_EN
    if (mul_done && mul_long_q && (rd != PC_IDX)) rf[rd] <= mul_lo;
`endif
    if (mul_done && (rn != PC_IDX)) rf[rn] <= mul_wd1;
  end

  assign bus.Adr       = bus.AdrSrc ? result : pc;
  assign bus.WriteData = b_q;
  assign bus.Instr     = ir;
  assign bus.MulBusy   = mul_busy;
  assign bus.MulDone   = mul_done;

endmodule

// File: tb/tb_mc_datapath.sv
// Directed self-checking bench for mc_datapath (WIDTH=32, NREG=16).
// Registers are observed through Adr = A + 0 (AdrSrc=1, ResultSrc=ALUResult, ALUSrcB=reserved).
// Expectations for the UMULL cases depend on LONG_MUL_EN.
module tb_mc_datapath;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  mc_datapath_if #(.WIDTH(WIDTH)) bus();

  mc_datapath #(.WIDTH(WIDTH), .NREG(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr();
    bus.PCWrite = 0; bus.AdrSrc = 0; bus.IRWrite = 0; bus.RegSrc = 2'b00;
    bus.RegWrite = 0; bus.ImmSrc = 2'b00; bus.ALUSrcA = 0; bus.ALUSrcB = 2'b00;
    bus.ALUControl = 2'b00; bus.ResultSrc = 2'b00; bus.MulStart = 0; bus.MulLong = 0;
  endtask

  task automatic fetch(input logic [31:0] word);
    bus.ReadData = word; bus.IRWrite = 1; bus.ALUSrcA = 1; bus.ALUSrcB = 2'b10;
    bus.ALUControl = 2'b00; bus.ResultSrc = 2'b10; bus.PCWrite = 1; bus.AdrSrc = 0;
    tick();
    clr();
  endtask

  task automatic load_ir(input logic [31:0] word);
    bus.ReadData = word; bus.IRWrite = 1;
    tick();
    clr();
  endtask

  task automatic write_reg(input logic [3:0] r, input logic [31:0] val);
    load_ir({16'h0000, r, 12'h000});
    bus.ReadData = val;
    tick();
    bus.RegWrite = 1; bus.ResultSrc = 2'b01;
    tick();
    clr();
  endtask

  task automatic read_reg(input logic [3:0] r, output logic [31:0] val);
    load_ir({12'h000, r, 16'h0000});
    tick();
    bus.ALUSrcA = 0; bus.ALUSrcB = 2'b11; bus.ALUControl = 2'b00;
    bus.ResultSrc = 2'b10; bus.AdrSrc = 1;
    #1 val = bus.Adr;
    clr();
  endtask

  // A <- R[ra], B <- R[rb], then start with instr in IR; returns at cycle 1.
  task automatic start_mul(input logic [3:0] ra, input logic [3:0] rb,
                           input logic [31:0] instr, input logic lng);
    load_ir({12'h000, ra, 12'h000, rb});
    tick();
    bus.ReadData = instr; bus.IRWrite = 1; bus.MulStart = 1; bus.MulLong = lng;
    tick();
    clr();
  endtask

  task automatic mul_window(input int restart_cyc, input bit rw_in_done,
                            output int done_cyc, output int ndone,
                            output logic busy1, output logic busy_end);
    done_cyc = -1; ndone = 0; busy1 = 0; busy_end = 1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc == 1) busy1 = bus.MulBusy;
      if (cyc == WIDTH + 2) busy_end = bus.MulBusy;
      if (bus.MulDone) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
        if (rw_in_done) begin bus.RegWrite = 1; bus.ResultSrc = 2'b01; end
      end
      if (cyc == restart_cyc) bus.MulStart = 1;
      tick();
      bus.MulStart = 0; bus.RegWrite = 0; bus.ResultSrc = 2'b00;
    end
  endtask

  task automatic test_reset();
    bus.AdrSrc = 0;
    #1;
    total++; if (bus.Adr !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want %h", bus.Adr, 32'h0); end
    total++; if (bus.Instr !== 32'h0) begin bad++; $display("FAIL reset_ir: got %h want %h", bus.Instr, 32'h0); end
    fetch(32'hE000_0000);
    // Mid-fetch reset.
    bus.ReadData = 32'hE1A0_1002; bus.IRWrite = 1; bus.ALUSrcA = 1; bus.ALUSrcB = 2'b10;
    bus.ResultSrc = 2'b10; bus.PCWrite = 1; bus.AdrSrc = 0;
    #2 reset = 1;
    #1;
    total++; if (bus.Adr !== 32'h0) begin bad++; $display("FAIL midreset_pc: got %h want %h", bus.Adr, 32'h0); end
    total++; if (bus.Instr !== 32'h0) begin bad++; $display("FAIL midreset_ir: got %h want %h", bus.Instr, 32'h0); end
    total++; if (bus.MulBusy !== 1'b0) begin bad++; $display("FAIL midreset_busy: got %b want 0", bus.MulBusy); end
    total++; if (bus.MulDone !== 1'b0) begin bad++; $display("FAIL midreset_done: got %b want 0", bus.MulDone); end
    tick();
    reset = 0;
    tick();
    clr();
    #1;
    total++; if (bus.Adr !== 32'h4) begin bad++; $display("FAIL fetch_pc: got %h want %h", bus.Adr, 32'h4); end
    total++; if (bus.Instr !== 32'hE1A0_1002) begin bad++; $display("FAIL fetch_ir: got %h want %h", bus.Instr, 32'hE1A0_1002); end
  endtask

  task automatic test_pc_alias();
    logic [31:0] v;
    bus.RegSrc = 2'b01;
    tick();
    bus.ALUSrcB = 2'b11; bus.ResultSrc = 2'b10; bus.AdrSrc = 1;
    #1;
    total++; if (bus.Adr !== 32'h8) begin bad++; $display("FAIL r15_read: got %h want %h", bus.Adr, 32'h8); end
    clr();
    fetch(32'h0000_F000);
    bus.ReadData = 32'h1234_5678;
    tick();
    bus.RegWrite = 1; bus.ResultSrc = 2'b01;
    tick();
    clr();
    #1;
    total++; if (bus.Adr !== 32'h8) begin bad++; $display("FAIL r15_write_pc: got %h want %h", bus.Adr, 32'h8); end
    read_reg(4'd15, v);
    total++; if (v !== 32'hC) begin bad++; $display("FAIL r15_after_write: got %h want %h", v, 32'hC); end
  endtask

  task automatic test_alu();
    load_ir(32'h0006_0001);
    tick();
    bus.ALUSrcA = 0; bus.ALUSrcB = 2'b01; bus.ImmSrc = 2'b00; bus.ResultSrc = 2'b10; bus.AdrSrc = 1;
    bus.ALUControl = 2'b00; #1;
    total++; if ({bus.Adr, bus.ALUFlags} !== {32'h0, 4'b0110}) begin bad++; $display("FAIL alu_add: got %h/%b want %h/%b", bus.Adr, bus.ALUFlags, 32'h0, 4'b0110); end
    bus.ALUControl = 2'b01; #1;
    total++; if ({bus.Adr, bus.ALUFlags} !== {32'hFFFF_FFFE, 4'b1010}) begin bad++; $display("FAIL alu_sub: got %h/%b want %h/%b", bus.Adr, bus.ALUFlags, 32'hFFFF_FFFE, 4'b1010); end
    bus.ALUControl = 2'b10; #1;
    total++; if ({bus.Adr, bus.ALUFlags} !== {32'h1, 4'b0000}) begin bad++; $display("FAIL alu_and: got %h/%b want %h/%b", bus.Adr, bus.ALUFlags, 32'h1, 4'b0000); end
    bus.ALUControl = 2'b11; #1;
    total++; if ({bus.Adr, bus.ALUFlags} !== {32'hFFFF_FFFF, 4'b1000}) begin bad++; $display("FAIL alu_or: got %h/%b want %h/%b", bus.Adr, bus.ALUFlags, 32'hFFFF_FFFF, 4'b1000); end
    tick();
    bus.ALUControl = 2'b10; bus.ImmSrc = 2'b10; #1;
    total++; if (bus.Adr !== 32'h0018_0004) begin bad++; $display("FAIL ext_branch: got %h want %h", bus.Adr, 32'h0018_0004); end
    bus.ImmSrc = 2'b01; #1;
    total++; if (bus.Adr !== 32'h1) begin bad++; $display("FAIL ext_imm12: got %h want %h", bus.Adr, 32'h1); end
    clr();
    load_ir(32'h0008_0001);
    tick();
    bus.ALUSrcB = 2'b01; bus.ResultSrc = 2'b10; bus.AdrSrc = 1; bus.ALUControl = 2'b00; #1;
    total++; if ({bus.Adr, bus.ALUFlags} !== {32'h8000_0000, 4'b1001}) begin bad++; $display("FAIL alu_ovf: got %h/%b want %h/%b", bus.Adr, bus.ALUFlags, 32'h8000_0000, 4'b1001); end
    clr();
  endtask

  task automatic test_mul();
    int dc, nd; logic b1, be; logic [31:0] v;
    start_mul(4'd4, 4'd5, 32'h0003_0000, 1'b0);
    mul_window(0, 0, dc, nd, b1, be);
    total++; if (b1 !== 1'b1) begin bad++; $display("FAIL mul_busy_c1: got %b want 1", b1); end
    total++; if (dc !== 33) begin bad++; $display("FAIL mul_done_cycle: got %0d want 33", dc); end
    total++; if (nd !== 1) begin bad++; $display("FAIL mul_done_count: got %0d want 1", nd); end
    total++; if (be !== 1'b0) begin bad++; $display("FAIL mul_busy_c34: got %b want 0", be); end
    read_reg(4'd3, v);
    total++; if (v !== 32'd42) begin bad++; $display("FAIL mul_result: got %h want %h", v, 32'd42); end
  endtask

  task automatic test_long_mul();
    int dc, nd; logic b1, be; logic [31:0] v1, v2;
    write_reg(4'd1, 32'h0000_AAAA);
    write_reg(4'd2, 32'h0000_BBBB);
    start_mul(4'd6, 4'd6, 32'h0002_1000, 1'b1);
    mul_window(0, 0, dc, nd, b1, be);
    read_reg(4'd1, v1);
    read_reg(4'd2, v2);
`ifdef LONG_MUL_EN
    total++; if (v1 !== 32'h0000_0001) begin bad++; $display("FAIL umull_lo: got %h want %h", v1, 32'h1); end
    total++; if (v2 !== 32'hFFFF_FFFE) begin bad++; $display("FAIL umull_hi: got %h want %h", v2, 32'hFFFF_FFFE); end
`else
    total++; if (v1 !== 32'h0000_AAAA) begin bad++; $display("FAIL umull_lo_untouched: got %h want %h", v1, 32'hAAAA); end
    total++; if (v2 !== 32'h0000_0001) begin bad++; $display("FAIL umull_as_mul: got %h want %h", v2, 32'h1); end
`endif
  endtask

  task automatic test_back_to_back_start();
    int dc, nd; logic b1, be; logic [31:0] v;
    write_reg(4'd9, 32'h0);
    start_mul(4'd4, 4'd5, 32'h0009_0000, 1'b0);
    mul_window(5, 0, dc, nd, b1, be);
    total++; if (nd !== 1) begin bad++; $display("FAIL restart_done_count: got %0d want 1", nd); end
    total++; if (dc !== 33) begin bad++; $display("FAIL restart_done_cycle: got %0d want 33", dc); end
    read_reg(4'd9, v);
    total++; if (v !== 32'd42) begin bad++; $display("FAIL restart_result: got %h want %h", v, 32'd42); end
  endtask

  task automatic test_write_priority();
    int dc, nd; logic b1, be; logic [31:0] v;
    write_reg(4'd10, 32'h10);
    start_mul(4'd6, 4'd10, 32'h0002_2000, 1'b1);
    bus.ReadData = 32'h0000_1234;
    mul_window(0, 1, dc, nd, b1, be);
    read_reg(4'd2, v);
`ifdef LONG_MUL_EN
    total++; if (v !== 32'h0000_000F) begin bad++; $display("FAIL prio_r2: got %h want %h", v, 32'hF); end
`else
    total++; if (v !== 32'hFFFF_FFF0) begin bad++; $display("FAIL prio_r2: got %h want %h", v, 32'hFFFF_FFF0); end
`endif
  endtask

  task automatic test_reset_in_run();
    int nd; logic [31:0] v;
    write_reg(4'd7, 32'h55);
    start_mul(4'd4, 4'd5, 32'h0007_0000, 1'b0);
    for (int c = 1; c < 10; c++) tick();
    reset = 1;
    #1;
    total++; if (bus.MulBusy !== 1'b0) begin bad++; $display("FAIL rst_run_busy: got %b want 0", bus.MulBusy); end
    tick();
    reset = 0;
    #1;
    total++; if (bus.MulBusy !== 1'b0) begin bad++; $display("FAIL rst_run_idle: got %b want 0", bus.MulBusy); end
    nd = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.MulDone) nd++;
      tick();
    end
    total++; if (nd !== 0) begin bad++; $display("FAIL rst_run_done: got %0d want 0", nd); end
    read_reg(4'd7, v);
    total++; if (v !== 32'h55) begin bad++; $display("FAIL rst_run_nowrite: got %h want %h", v, 32'h55); end
  endtask

  initial begin
    reset = 1;
    bus.ReadData = '0;
    clr();
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    test_reset();
    test_pc_alias();
    write_reg(4'd4, 32'd7);
    write_reg(4'd5, 32'd6);
    write_reg(4'd6, 32'hFFFF_FFFF);
    write_reg(4'd8, 32'h7FFF_FFFF);
    test_alu();
    test_mul();
    test_long_mul();
    test_back_to_back_start();
    test_write_priority();
    test_reset_in_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
